spi_fsm: RTL and testbench

- Transaction controller for the SPI peripheral.
- Sits directly downstream of the input-conditioned chip-select/SCLK edges and the shift register's serial LSB.
- Decodes each CS-framed transaction as 7 address bits + 1 R/W bit, then either a write (8 data bits committed to data memory) or a read (memory word loaded into the shift register and shifted out on MISO).
- Drives the address latch, data memory, shift register parallel load and MISO tri-state buffer.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_bit_counter.sv | 38 +++
 rtl/spi_fsm.sv | 150 +++++++++++++++
 tb/tb_spi_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction controller: state encoding and
// frame field widths.
package spi_pkg;

   localparam int ADDR_BITS_DEF = 7;
   localparam int DATA_BITS_DEF = 8;
   localparam int CNT_W_DEF     = 4;
   localparam int HDR_BITS_DEF  = ADDR_BITS_DEF + 1;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      GET_ADDR     = 3'd1,
      GOT_ADDR     = 3'd2,
      READ_LOAD    = 3'd3,
      READ_SHIFT   = 3'd4,
      WRITE_SHIFT  = 3'd5,
      WRITE_COMMIT = 3'd6,
      DONE         = 3'd7
   } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Bit counter for header/data phases: synchronous clear, increment enable and
// a terminal-count flag raised on the increment that reaches the limit.
module spi_bit_counter #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] cnt_plus;

   assign cnt_plus = cnt_q + CNT_W'(1);
   assign tc_o     = inc_i && (cnt_plus == limit_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_plus;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_fsm.sv
// SPI transaction controller: frames a CS-delimited transaction into header,
// then a write commit or a read load/shift-out, with Moore enables.
//
// state        | meaning
// IDLE         | waiting for cs_n low
// GET_ADDR     | counting header bits on sclk rising edges
// GOT_ADDR     | latch address, capture R/W bit (1 clk)
// READ_LOAD    | parallel-load memory word into shift register (1 clk)
// READ_SHIFT   | drive MISO, counting falling edges
// WRITE_SHIFT  | counting data bits on rising edges
// WRITE_COMMIT | write shifted data to memory (1 clk)
// DONE         | frame complete, wait for cs_n high
module spi_fsm
   import spi_pkg::*;
#(
   parameter int ADDR_BITS = ADDR_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic cs_n,
   input  logic sclk_posedge,
   input  logic sclk_negedge,
   input  logic sr_lsb,
   output logic addr_we,
   output logic dm_we,
   output logic sr_we,
   output logic miso_buff,
   output logic busy
);

   localparam logic [CNT_W-1:0] HDR_LIMIT  = CNT_W'(ADDR_BITS + 1);
   localparam logic [CNT_W-1:0] DATA_LIMIT = CNT_W'(DATA_BITS);

   spi_state_e       state_q;
   spi_state_e       state_d;
   logic             rw_q;
   logic             rw_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_tc;
   logic             data_edge;
   logic [CNT_W-1:0] cnt_limit;

   spi_bit_counter #(
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (cnt_inc),
      .limit_i (cnt_limit),
      .tc_o    (cnt_tc)
   );

   // Edge qualification kept apart from next-state logic so the counter's
   // terminal flag never feeds back into its own enable.
   always_comb begin
      data_edge = rw_q ? sclk_negedge : sclk_posedge;
      cnt_inc   = 1'b0;
      cnt_limit = HDR_LIMIT;
      case (state_q)
         GET_ADDR: begin
            cnt_inc = sclk_posedge;
         end
         READ_SHIFT, WRITE_SHIFT: begin
            cnt_inc   = data_edge;
            cnt_limit = DATA_LIMIT;
         end
         default: begin
            cnt_inc = 1'b0;
         end
      endcase
      if (cs_n) begin
         cnt_inc = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      cnt_clr = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (!cs_n) begin
               state_d = GET_ADDR;
            end
         end
         GET_ADDR: begin
            if (cnt_tc) begin
               state_d = GOT_ADDR;
            end
         end
         GOT_ADDR: begin
            rw_d    = sr_lsb;
            state_d = sr_lsb ? READ_LOAD : WRITE_SHIFT;
         end
         READ_LOAD: begin
            state_d = READ_SHIFT;
         end
         READ_SHIFT: begin
            if (cnt_tc) begin
               state_d = DONE;
            end
         end
         WRITE_SHIFT: begin
            if (cnt_tc) begin
               state_d = WRITE_COMMIT;
            end
         end
         WRITE_COMMIT: begin
            state_d = DONE;
         end
         DONE: begin
            if (cs_n) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Chip-select release wins over everything; an unfinished write is dropped.
      if (cs_n && (state_q != IDLE)) begin
         state_d = IDLE;
      end
      if (state_d != state_q) begin
         cnt_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
      end
   end

   assign addr_we   = (state_q == GOT_ADDR);
   assign sr_we     = (state_q == READ_LOAD);
   assign miso_buff = (state_q == READ_SHIFT);
   assign dm_we     = (state_q == WRITE_COMMIT);
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: randomized SPI frames, expectations derived
// from edge counts of the applied stimulus.
module tb_spi_fsm;

   logic clk = 1'b0;
   logic reset;
   logic cs_n;
   logic sclk_posedge;
   logic sclk_negedge;
   logic sr_lsb;
   logic addr_we;
   logic dm_we;
   logic sr_we;
   logic miso_buff;
   logic busy;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   int n_addr, n_sr, n_dm, n_miso;
   int c_addr, c_sr, c_dm, first_miso, last_miso;
   logic first_busy, abort_busy, exit_busy;

   spi_fsm dut (
      .clk          (clk),
      .reset        (reset),
      .cs_n         (cs_n),
      .sclk_posedge (sclk_posedge),
      .sclk_negedge (sclk_negedge),
      .sr_lsb       (sr_lsb),
      .addr_we      (addr_we),
      .dm_we        (dm_we),
      .sr_we        (sr_we),
      .miso_buff    (miso_buff),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic clear_log();
      n_addr = 0; n_sr = 0; n_dm = 0; n_miso = 0;
      c_addr = -1; c_sr = -1; c_dm = -1; first_miso = -1; last_miso = -1;
   endtask

   // Apply one clk of inputs; the sample after the edge is tagged with cyc.
   task automatic step(input logic cs, input logic pe, input logic ne, input logic lsb);
      cs_n = cs; sclk_posedge = pe; sclk_negedge = ne; sr_lsb = lsb;
      @(posedge clk);
      #1;
      cyc++;
      if (addr_we)   begin n_addr++; c_addr = cyc; end
      if (sr_we)     begin n_sr++;   c_sr   = cyc; end
      if (dm_we)     begin n_dm++;   c_dm   = cyc; end
      if (miso_buff) begin
         if (n_miso == 0) first_miso = cyc;
         n_miso++;
         last_miso = cyc;
      end
   endtask

   // One framed transaction. k_hdr = sample index of the 8th header posedge,
   // k_data = sample index of the last relevant data edge applied.
   task automatic run_txn(input logic rw, input int abort_after, input logic noise,
                          input int extra, input logic extra_pos_only,
                          output int k_hdr, output int k_data);
      int gaps;
      clear_log();
      k_hdr = -1; k_data = -1; abort_busy = 1'b1; exit_busy = 1'b1;
      step(1'b0, 1'b0, 1'b0, rb());
      first_busy = busy;
      for (int i = 0; i < 8; i++) begin
         gaps = int'($urandom_range(0, 2));
         repeat (gaps) step(1'b0, 1'b0, noise & rb(), rb());
         step(1'b0, 1'b1, noise & rb(), (i == 7) ? rw : rb());
      end
      k_hdr = cyc;
      // GOT_ADDR (and READ_LOAD for reads): stray edges here must be ignored
      repeat (rw ? 2 : 1) step(1'b0, rb(), rb(), rw);
      for (int i = 0; i < 8; i++) begin
         if (abort_after == i) begin
            step(1'b1, 1'b0, 1'b0, rw);
            abort_busy = busy;
            break;
         end
         gaps = int'($urandom_range(0, 2));
         repeat (gaps) step(1'b0, rw & noise & rb(), !rw & noise & rb(), rw);
         if (rw) step(1'b0, noise & rb(), 1'b1, rw);
         else    step(1'b0, 1'b1, (noise && i == 2) ? 1'b1 : (noise & rb()), rw);
         k_data = cyc;
      end
      if (abort_after < 0) begin
         repeat (extra) step(1'b0, extra_pos_only ? 1'b1 : rb(),
                             extra_pos_only ? 1'b0 : rb(), rb());
         step(1'b1, 1'b0, 1'b0, 1'b0);
         exit_busy = busy;
      end
      step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      int kh, kd;
      reset = 1'b1;
      cs_n = 1'b1; sclk_posedge = 1'b0; sclk_negedge = 1'b0; sr_lsb = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({addr_we, dm_we, sr_we, miso_buff, busy} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_outs: got %b want 00000", {addr_we, dm_we, sr_we, miso_buff, busy});
      end
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset_busy: got %b want 1", busy);
      end
      #3 reset = 1'b1;
      #1;
      vectors++;
      if ({addr_we, dm_we, sr_we, miso_buff, busy} !== 5'b0) begin
         miscompares++;
         $display("FAIL async_reset_outs: got %b want 00000", {addr_we, dm_we, sr_we, miso_buff, busy});
      end
      cs_n = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      run_txn(1'b0, -1, 1'b0, 0, 1'b0, kh, kd);
      vectors++;
      if (c_addr !== kh || n_addr !== 1) begin
         miscompares++;
         $display("FAIL post_reset_addr: got cyc %0d cnt %0d want cyc %0d cnt 1", c_addr, n_addr, kh);
      end
      vectors++;
      if (c_dm !== kd || n_dm !== 1) begin
         miscompares++;
         $display("FAIL post_reset_dm: got cyc %0d cnt %0d want cyc %0d cnt 1", c_dm, n_dm, kd);
      end
   endtask

   task automatic test_write();
      int kh, kd;
      run_txn(1'b0, -1, 1'b0, 0, 1'b0, kh, kd);
      vectors++;
      if (first_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL wr_busy: got %b want 1", first_busy);
      end
      vectors++;
      if (c_addr !== kh || n_addr !== 1) begin
         miscompares++;
         $display("FAIL wr_addr_we: got cyc %0d cnt %0d want cyc %0d cnt 1", c_addr, n_addr, kh);
      end
      vectors++;
      if (c_dm !== kd || n_dm !== 1) begin
         miscompares++;
         $display("FAIL wr_dm_we: got cyc %0d cnt %0d want cyc %0d cnt 1", c_dm, n_dm, kd);
      end
      vectors++;
      if (n_miso !== 0 || n_sr !== 0) begin
         miscompares++;
         $display("FAIL wr_no_read: got miso %0d sr %0d want 0 0", n_miso, n_sr);
      end
      vectors++;
      if (exit_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL wr_exit_busy: got %b want 0", exit_busy);
      end
   endtask

   task automatic test_read();
      int kh, kd;
      run_txn(1'b1, -1, 1'b0, 0, 1'b0, kh, kd);
      vectors++;
      if (c_addr !== kh || n_addr !== 1) begin
         miscompares++;
         $display("FAIL rd_addr_we: got cyc %0d cnt %0d want cyc %0d cnt 1", c_addr, n_addr, kh);
      end
      vectors++;
      if (c_sr !== kh + 1 || n_sr !== 1) begin
         miscompares++;
         $display("FAIL rd_sr_we: got cyc %0d cnt %0d want cyc %0d cnt 1", c_sr, n_sr, kh + 1);
      end
      vectors++;
      if (first_miso !== kh + 2) begin
         miscompares++;
         $display("FAIL rd_miso_start: got %0d want %0d", first_miso, kh + 2);
      end
      vectors++;
      if (last_miso !== kd - 1 || n_miso !== kd - kh - 2) begin
         miscompares++;
         $display("FAIL rd_miso_end: got last %0d cnt %0d want last %0d cnt %0d",
                  last_miso, n_miso, kd - 1, kd - kh - 2);
      end
      vectors++;
      if (n_dm !== 0) begin
         miscompares++;
         $display("FAIL rd_no_dm: got %0d want 0", n_dm);
      end
   endtask

   task automatic test_abort();
      int kh, kd;
      run_txn(1'b0, 5, 1'b0, 0, 1'b0, kh, kd);
      vectors++;
      if (abort_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_busy: got %b want 0", abort_busy);
      end
      vectors++;
      if (n_dm !== 0) begin
         miscompares++;
         $display("FAIL abort_dm: got %0d want 0", n_dm);
      end
      vectors++;
      if (n_addr !== 1) begin
         miscompares++;
         $display("FAIL abort_addr: got %0d want 1", n_addr);
      end
   endtask

   task automatic test_noise();
      int kh, kd;
      run_txn(1'b0, -1, 1'b1, 0, 1'b0, kh, kd);
      vectors++;
      if (c_addr !== kh) begin
         miscompares++;
         $display("FAIL noise_addr: got %0d want %0d", c_addr, kh);
      end
      vectors++;
      if (c_dm !== kd || n_dm !== 1) begin
         miscompares++;
         $display("FAIL noise_dm: got cyc %0d cnt %0d want cyc %0d cnt 1", c_dm, n_dm, kd);
      end
      run_txn(1'b1, -1, 1'b1, 0, 1'b0, kh, kd);
      vectors++;
      if (last_miso !== kd - 1 || first_miso !== kh + 2) begin
         miscompares++;
         $display("FAIL noise_miso: got %0d..%0d want %0d..%0d", first_miso, last_miso, kh + 2, kd - 1);
      end
   endtask

   task automatic test_extra();
      int kh, kd;
      run_txn(1'b0, -1, 1'b0, 3, 1'b1, kh, kd);
      vectors++;
      if (n_dm !== 1 || n_addr !== 1 || n_sr !== 0 || n_miso !== 0) begin
         miscompares++;
         $display("FAIL extra_enables: got dm %0d addr %0d sr %0d miso %0d want 1 1 0 0",
                  n_dm, n_addr, n_sr, n_miso);
      end
      vectors++;
      if (exit_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL extra_exit_busy: got %b want 0", exit_busy);
      end
      run_txn(1'b1, -1, 1'b0, 0, 1'b0, kh, kd);
      vectors++;
      if (c_addr !== kh || c_sr !== kh + 1 || last_miso !== kd - 1) begin
         miscompares++;
         $display("FAIL extra_follow: got addr %0d sr %0d miso_end %0d want %0d %0d %0d",
                  c_addr, c_sr, last_miso, kh, kh + 1, kd - 1);
      end
   endtask

   task automatic test_random();
      int kh, kd, ab, ex;
      logic rw, nz;
      for (int t = 0; t < 12; t++) begin
         rw = rb();
         nz = rb();
         ex = int'($urandom_range(0, 3));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_txn(rw, ab, nz, ex, 1'b0, kh, kd);
         vectors++;
         if (c_addr !== kh || n_addr !== 1) begin
            miscompares++;
            $display("FAIL rnd_addr[%0d]: got cyc %0d cnt %0d want cyc %0d cnt 1", t, c_addr, n_addr, kh);
         end
         if (ab >= 0) begin
            vectors++;
            if (abort_busy !== 1'b0 || n_dm !== 0) begin
               miscompares++;
               $display("FAIL rnd_abort[%0d]: got busy %b dm %0d want 0 0", t, abort_busy, n_dm);
            end
         end else if (rw) begin
            vectors++;
            if (c_sr !== kh + 1 || n_sr !== 1 || n_dm !== 0) begin
               miscompares++;
               $display("FAIL rnd_rd_sr[%0d]: got cyc %0d cnt %0d dm %0d want cyc %0d cnt 1 dm 0",
                        t, c_sr, n_sr, n_dm, kh + 1);
            end
            vectors++;
            if (last_miso !== kd - 1 || n_miso !== kd - kh - 2) begin
               miscompares++;
               $display("FAIL rnd_rd_miso[%0d]: got last %0d cnt %0d want last %0d cnt %0d",
                        t, last_miso, n_miso, kd - 1, kd - kh - 2);
            end
         end else begin
            vectors++;
            if (c_dm !== kd || n_dm !== 1 || n_miso !== 0 || n_sr !== 0) begin
               miscompares++;
               $display("FAIL rnd_wr[%0d]: got dm cyc %0d cnt %0d miso %0d sr %0d want %0d 1 0 0",
                        t, c_dm, n_dm, n_miso, n_sr, kd);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_noise();
      test_extra();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
